// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t        : arbiter FSM states (IDLE -> ACCESS -> DONE)
//   PORT_A, PORT_B : requester identifiers used for the winner and last-served flags
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin chooser (purely combinational).
// Ports:
//   req_a, req_b  : request lines of port A and port B
//   last_served   : port id that completed the most recent transaction
//   winner        : port id granted this cycle (meaningful only when valid)
//   valid         : at least one request is present
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_served,
    output logic winner,
    output logic valid
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        valid  = req_a | req_b;
        winner = PORT_A;
        if (req_a && req_b) begin
            // Contention: the port that was not served last goes next.
            winner = (last_served == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Each accepted request takes three cycles: IDLE (arbitrate and latch),
// ACCESS (drive the memory), DONE (ack the winner, capture read data).
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata      : port A request, write enable, address, write data
//   a_ack/a_rdata                  : port A completion pulse and read data
//   b_*                            : port B, same meaning as port A
//   mem_addr/mem_we/mem_wdata      : memory command outputs
//   mem_q                          : memory read data, valid one cycle after mem_addr
//   busy                           : high whenever the FSM is outside IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy
);

    state_t                state;
    logic                  win_id;
    logic                  last_served;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] a_rdata_q;
    logic [DATA_WIDTH-1:0] b_rdata_q;
    logic                  grant;
    logic                  grant_valid;

    arb_rr2 u_arb (
        .req_a       (a_req),
        .req_b       (b_req),
        .last_served (last_served),
        .winner      (grant),
        .valid       (grant_valid)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            win_id      <= PORT_A;
            last_served <= PORT_B;     // A wins the first simultaneous request
            lat_we      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        // The memory command registers double as the latch of
                        // the winner's request; they then hold outside ACCESS.
                        win_id    <= grant;
                        lat_we    <= (grant == PORT_B) ? b_we    : a_we;
                        mem_we    <= (grant == PORT_B) ? b_we    : a_we;
                        mem_addr  <= (grant == PORT_B) ? b_addr  : a_addr;
                        mem_wdata <= (grant == PORT_B) ? b_wdata : a_wdata;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_we <= 1'b0;
                    if (win_id == PORT_A) begin
                        a_ack <= 1'b1;
                    end else begin
                        b_ack <= 1'b1;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    if (!lat_we) begin
                        if (win_id == PORT_A) begin
                            a_rdata_q <= mem_q;
                        end else begin
                            b_rdata_q <= mem_q;
                        end
                    end
                    last_served <= win_id;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // mem_q is valid during DONE, so it is forwarded straight to the winner's
    // rdata while ack is high; the holding register takes over afterwards.
    assign a_rdata = (state == ST_DONE && win_id == PORT_A && !lat_we) ? mem_q : a_rdata_q;
    assign b_rdata = (state == ST_DONE && win_id == PORT_B && !lat_we) ? mem_q : b_rdata_q;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// two-port traffic compared against a transaction-level model (expected memory
// image, per-port expected read data, round-robin order).
module tb_mem_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;
    logic          busy;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_rdata   (b_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_q     (mem_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // 64x16 synchronous memory with one-cycle registered read.
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    // Bus monitor: ack counts, grant order, and mem_we sanity
    // (single-cycle, only while busy, never alongside an ack).
    int   a_ack_cnt = 0;
    int   b_ack_cnt = 0;
    int   we_cnt    = 0;
    int   we_bad    = 0;
    logic prev_we   = 1'b0;
    logic grants[$];
    always @(posedge clk) begin
        if (a_ack) begin
            a_ack_cnt <= a_ack_cnt + 1;
            grants.push_back(1'b0);
        end
        if (b_ack) begin
            b_ack_cnt <= b_ack_cnt + 1;
            grants.push_back(1'b1);
        end
        if (mem_we) begin
            we_cnt <= we_cnt + 1;
            if (!busy || a_ack || b_ack || prev_we) we_bad <= we_bad + 1;
        end
        prev_we <= mem_we;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One complete single-port transaction; lat is the number of cycles from
    // driving req to seeing ack (-1 on timeout). Returns with the FSM in IDLE.
    task automatic txn(input logic port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, output int lat);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
        end
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (port ? b_ack : a_ack) begin
                lat = i;
                break;
            end
        end
        if (port) b_req = 1'b0; else a_req = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_ack"},     32'(a_ack),     32'd0);
        check({tag, "_b_ack"},     32'(b_ack),     32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_a_rdata"},   32'(a_rdata),   32'd0);
        check({tag, "_b_rdata"},   32'(b_rdata),   32'd0);
    endtask

    // Random-phase state and reference model.
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_rd  [2];
    logic          model_last;
    logic          r_req   [2];
    logic          r_we    [2];
    logic [AW-1:0] r_addr  [2];
    logic [DW-1:0] r_data  [2];
    logic          order   [2];
    int            n_txn;
    int            lat;
    int            timeouts;
    int            snap_a, snap_b, snap_we, snap_bad, snap_g;
    logic          found;
    logic          port;

    initial begin
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // A writes 0x1234 to address 5.
        snap_we = we_cnt;
        a_req = 1; a_we = 1; a_addr = 6'd5; a_wdata = 16'h1234;
        tick();
        check("wr_access_mem_we",    32'(mem_we),    32'd1);
        check("wr_access_mem_addr",  32'(mem_addr),  32'd5);
        check("wr_access_mem_wdata", 32'(mem_wdata), 32'h1234);
        check("wr_access_busy",      32'(busy),      32'd1);
        check("wr_access_a_ack",     32'(a_ack),     32'd0);
        tick();
        check("wr_done_a_ack",  32'(a_ack),   32'd1);
        check("wr_done_mem_we", 32'(mem_we),  32'd0);
        check("wr_done_a_rd",   32'(a_rdata), 32'd0);
        check("wr_done_b_ack",  32'(b_ack),   32'd0);
        a_req = 0; a_we = 0;
        tick();
        check("wr_idle_a_ack",  32'(a_ack),            32'd0);
        check("wr_idle_busy",   32'(busy),             32'd0);
        check("wr_idle_a_rd",   32'(a_rdata),          32'd0);
        check("wr_we_pulses",   32'(we_cnt - snap_we), 32'd1);

        // B reads address 5 back.
        b_req = 1; b_we = 0; b_addr = 6'd5;
        tick();
        check("rd_access_mem_we",   32'(mem_we),   32'd0);
        check("rd_access_mem_addr", 32'(mem_addr), 32'd5);
        check("rd_access_b_ack",    32'(b_ack),    32'd0);
        tick();
        check("rd_done_b_ack",  32'(b_ack),   32'd1);
        check("rd_done_b_rd",   32'(b_rdata), 32'h1234);
        check("rd_done_a_ack",  32'(a_ack),   32'd0);
        check("rd_done_a_rd",   32'(a_rdata), 32'd0);
        b_req = 0;
        tick();
        check("rd_idle_b_ack",  32'(b_ack),   32'd0);
        check("rd_idle_b_rd",   32'(b_rdata), 32'h1234);

        // Simultaneous reads from reset: A first, then B, six cycles in all.
        txn(1'b0, 1'b1, 6'd3, 16'hAAAA, lat);
        check("pre_wr3_lat", 32'(lat), 32'd2);
        txn(1'b0, 1'b1, 6'd7, 16'h5555, lat);
        check("pre_wr7_lat", 32'(lat), 32'd2);
        pulse_reset();
        a_req = 1; a_we = 0; a_addr = 6'd3;
        b_req = 1; b_we = 0; b_addr = 6'd7;
        tick();
        tick();
        check("both_c2_a_ack", 32'(a_ack),   32'd1);
        check("both_c2_b_ack", 32'(b_ack),   32'd0);
        check("both_c2_a_rd",  32'(a_rdata), 32'hAAAA);
        a_req = 0;
        tick();
        check("both_c3_acks",  32'({a_ack, b_ack}), 32'd0);
        tick();
        check("both_c4_addr",  32'(mem_addr), 32'd7);
        tick();
        check("both_c5_b_ack", 32'(b_ack),   32'd1);
        check("both_c5_b_rd",  32'(b_rdata), 32'h5555);
        check("both_c5_a_rd",  32'(a_rdata), 32'hAAAA);
        check("both_c5_a_ack", 32'(a_ack),   32'd0);
        b_req = 0;
        tick();

        // Continuous requests from both ports for eight transactions.
        pulse_reset();
        snap_a = a_ack_cnt; snap_b = b_ack_cnt; snap_we = we_cnt;
        snap_bad = we_bad; snap_g = grants.size();
        a_req = 1; a_we = 1; a_addr = 6'd10; a_wdata = 16'hA0A0;
        b_req = 1; b_we = 0; b_addr = 6'd10;
        repeat (23) tick();
        check("cont_last_b_ack", 32'(b_ack), 32'd1);
        a_req = 0; b_req = 0;
        tick();
        tick();
        check("cont_grants", 32'(grants.size() - snap_g), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (snap_g + i < grants.size())
                check($sformatf("cont_grant_%0d", i), 32'(grants[snap_g + i]), 32'(i % 2));
        end
        check("cont_a_acks",   32'(a_ack_cnt - snap_a),  32'd4);
        check("cont_b_acks",   32'(b_ack_cnt - snap_b),  32'd4);
        check("cont_we",       32'(we_cnt - snap_we),    32'd4);
        check("cont_we_bad",   32'(we_bad - snap_bad),   32'd0);
        check("cont_b_rd",     32'(b_rdata),             32'hA0A0);

        // Reset pulsed in the ACCESS cycle of an A write.
        snap_a = a_ack_cnt;
        a_req = 1; a_we = 1; a_addr = 6'd20; a_wdata = 16'hBEEF;
        tick();
        check("abort_in_access", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        a_req = 0; a_we = 0;
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("abort_no_a_ack", 32'(a_ack_cnt - snap_a), 32'd0);
        txn(1'b1, 1'b0, 6'd5, 16'h0000, lat);
        check("abort_b_lat", 32'(lat),     32'd2);
        check("abort_b_rd",  32'(b_rdata), 32'h1234);

        // Address change during ACCESS must not affect the transaction.
        txn(1'b0, 1'b1, 6'd2, 16'h0222, lat);
        txn(1'b0, 1'b1, 6'd9, 16'h0999, lat);
        a_req = 1; a_we = 0; a_addr = 6'd2;
        tick();
        a_addr = 6'd9;
        #1;
        check("addr_hold_mem_addr", 32'(mem_addr), 32'd2);
        tick();
        check("addr_hold_a_ack", 32'(a_ack),   32'd1);
        check("addr_hold_a_rd",  32'(a_rdata), 32'h0222);
        a_req = 0;
        tick();

        // Random traffic. Fill the memory through port B first so the model
        // knows every word; B is then the last-served port.
        timeouts = 0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = DW'($urandom);
            txn(1'b1, 1'b1, AW'(i), ref_mem[i], lat);
            if (lat < 0) timeouts++;
        end
        check("fill_timeouts", 32'(timeouts), 32'd0);
        exp_rd[0]  = 16'h0222;
        exp_rd[1]  = 16'h1234;
        model_last = 1'b1;

        for (int round = 0; round < 40; round++) begin
            for (int p = 0; p < 2; p++) begin
                r_req[p]  = 1'($urandom_range(0, 1));
                r_we[p]   = 1'($urandom_range(0, 1));
                r_addr[p] = AW'($urandom_range(0, 63));
                r_data[p] = DW'($urandom);
            end
            if (!r_req[0] && !r_req[1]) r_req[$urandom_range(0, 1)] = 1'b1;
            if (r_req[0] && r_req[1]) begin
                order[0] = ~model_last;
                order[1] = model_last;
                n_txn = 2;
            end else begin
                order[0] = r_req[1];
                n_txn = 1;
            end
            a_req = r_req[0]; a_we = r_we[0]; a_addr = r_addr[0]; a_wdata = r_data[0];
            b_req = r_req[1]; b_we = r_we[1]; b_addr = r_addr[1]; b_wdata = r_data[1];

            for (int t = 0; t < n_txn; t++) begin
                port  = order[t];
                found = 1'b0;
                for (int c = 0; c < 8 && !found; c++) begin
                    tick();
                    if (a_ack || b_ack) found = 1'b1;
                end
                check($sformatf("rnd%0d_ack_seen", round), 32'(found), 32'd1);
                check($sformatf("rnd%0d_winner", round), 32'({a_ack, b_ack}),
                      port ? 32'd1 : 32'd2);
                if (r_we[port]) ref_mem[r_addr[port]] = r_data[port];
                else            exp_rd[port] = ref_mem[r_addr[port]];
                check($sformatf("rnd%0d_a_rd", round), 32'(a_rdata), 32'(exp_rd[0]));
                check($sformatf("rnd%0d_b_rd", round), 32'(b_rdata), 32'(exp_rd[1]));
                model_last = port;
                if (port) b_req = 1'b0; else a_req = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
